// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake and data bundle for nibble_serial_add_ctrl.
// The sub port exists only when NIBBLE_ADD_SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef NIBBLE_ADD_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder built from one 4-bit ripple-carry stage reused over WIDTH/4 cycles, LSB first.
// Define NIBBLE_ADD_SUB_EN to add a subtract mode (a - b) selected by bus.sub at accept.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // The 4-bit ripple-carry stage shared by every nibble step.
  function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [3:0] s;
    logic       cy;
    cy = c;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    return {cy, s};
  endfunction

  state_e                state_q, state_d;
  logic [NIB-1:0][3:0]   a_q, a_d;
  logic [NIB-1:0][3:0]   b_q, b_d;
  logic [NIB-1:0][3:0]   sum_q, sum_d;
  logic                  carry_q, carry_d;
  logic [IdxW-1:0]       idx_q, idx_d;
`ifdef NIBBLE_ADD_SUB_EN
  logic                  sub_q, sub_d;
`endif

  logic [3:0] b_nib;
  logic [4:0] nib_res;

  always_comb begin
    b_nib = b_q[idx_q];
`ifdef NIBBLE_ADD_SUB_EN
    if (sub_q) b_nib = ~b_nib;
`endif
    nib_res = rca4(a_q[idx_q], b_nib, carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
`ifdef NIBBLE_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
`ifdef NIBBLE_ADD_SUB_EN
          sub_d   = bus.sub;
          // Two's-complement subtract: invert b and inject +1 as the initial carry.
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          carry_d = bus.cin;
`endif
        end
      end
      StRun: begin
        sum_d[idx_q] = nib_res[3:0];
        carry_d      = nib_res[4];
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
`ifdef NIBBLE_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
`ifdef NIBBLE_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StRun);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at WIDTH=16; subtract vectors run when
// NIBBLE_ADD_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "/out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "/busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Accept one operation, scramble the inputs, check the 4 RUN cycles, then the result.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic s, input logic [15:0] es, input logic ec);
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = c;
`ifdef NIBBLE_ADD_SUB_EN
    bus.sub      = s;
`endif
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.a        = 16'hDEAD;
    bus.b        = 16'hBEEF;
    bus.cin      = ~c;
`ifdef NIBBLE_ADD_SUB_EN
    bus.sub      = ~s;
`endif
    for (int i = 0; i < 4; i++) begin
      check({tag, "/run_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "/run_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "/run_out_valid"}, 32'(bus.out_valid), 32'd0);
      step();
    end
    check({tag, "/out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "/sum"}, 32'(bus.sum), 32'(es));
    check({tag, "/cout"}, 32'(bus.cout), 32'(ec));
    check({tag, "/done_busy"}, 32'(bus.busy), 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_idle({tag, "/after"});
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
    bus.sub       = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    check_idle("reset");
    check("reset/sum", 32'(bus.sum), 32'h0);
    check("reset/cout", 32'(bus.cout), 32'h0);

    run_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("carry_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);

    // Stall: result held while new operands wait on in_valid.
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.a = 16'h0100;
    bus.b = 16'h0200;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      check("stall/out_valid", 32'(bus.out_valid), 32'd1);
      check("stall/sum", 32'(bus.sum), 32'h3333);
      check("stall/cout", 32'(bus.cout), 32'd0);
      check("stall/in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_idle("stall/release");
    step();
    bus.in_valid = 1'b0;
    bus.a        = 16'hFFFF;
    bus.b        = 16'hFFFF;
    check("stall/next_busy", 32'(bus.busy), 32'd1);
    repeat (4) step();
    check("stall/next_out_valid", 32'(bus.out_valid), 32'd1);
    check("stall/next_sum", 32'(bus.sum), 32'h0300);
    check("stall/next_cout", 32'(bus.cout), 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_idle("stall/next_after");

    // Reset during the second RUN cycle discards the operation.
    bus.a        = 16'hAAAA;
    bus.b        = 16'h5555;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    check("abort/busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("abort");
    check("abort/sum", 32'(bus.sum), 32'h0);
    check("abort/cout", 32'(bus.cout), 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("abort/no_result", 32'(bus.out_valid), 32'd0);
      step();
    end

    // Back-to-back with out_ready held high and in_valid held.
    bus.a        = 16'h0F0F;
    bus.b        = 16'h0101;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.a = 16'h8000;
    bus.b = 16'h8000;
    for (int t = 0; t < 12; t++) begin
      check("b2b/out_valid", 32'(bus.out_valid), 32'((t == 4) || (t == 10)));
      if (t == 4) begin
        check("b2b/sum0", 32'(bus.sum), 32'h1010);
        check("b2b/cout0", 32'(bus.cout), 32'd0);
        check("b2b/no_bypass", 32'(bus.in_ready), 32'd0);
      end
      if (t == 5) check("b2b/idle_ready", 32'(bus.in_ready), 32'd1);
      if (t == 10) begin
        check("b2b/sum1", 32'(bus.sum), 32'h0000);
        check("b2b/cout1", 32'(bus.cout), 32'd1);
        bus.in_valid = 1'b0;
      end
      step();
    end
    bus.out_ready = 1'b0;
    check_idle("b2b/after");

`ifdef NIBBLE_ADD_SUB_EN
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_7_5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    run_op("sub0_add", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
